mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Responder end of the load/store memory request interface driven by the load-store buffer.
- Serialises 8/16/32-bit loads and stores onto the single-port, byte-wide, little-endian RAM bus.
- Holds committed stores in a small FIFO, because store requests are one-cycle pulses with no backpressure.
- Returns load data with a one-cycle done pulse.

Parameters:
- STQ_DEPTH, 4, store FIFO entries; must be a power of two, at least 2.
- STQ_LOG, 2, log2(STQ_DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, all state and outputs hold
- flush  in  1  branch-mispredict flush; aborts a pending load only
- ld_req  in  1  load request level; held high until ld_done is seen
- st_req  in  1  store request, one-cycle pulse
- req_len  in  6  access width in bits: 8, 16 or 32
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bytes used
- ld_done  out  1  one-cycle pulse; ld_data valid in the same cycle
- ld_data  out  32  load result, zero-extended; the requester sign-extends
- st_full  out  1  store FIFO holds STQ_DEPTH-1 or more entries
- ram_din  in  8  RAM read byte, valid one cycle after ram_a
- ram_dout  out  8  RAM write byte
- ram_a  out  32  RAM byte address
- ram_wr  out  1  1 = write, 0 = read

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE; FIFO head = tail = 0; byte counter = 0.
  - ld_done=0, ld_data=0, ram_wr=0, ram_a=0, ram_dout=0.
  - rst takes priority over rdy, flush and requests.
- rdy=0: no state changes; registered outputs hold. The cycle is not counted towards any latency.
- Store intake: an st_req cycle with rdy=1 pushes {addr, len, wdata} at the FIFO tail, in any FSM state and regardless of flush. st_full is combinational from the occupancy count. A push while the FIFO is full is a protocol violation; the bench asserts on it.
- FSM states are IDLE, ST, LD, DONE. A byte counter k counts 0..n-1, where n = req_len>>3.
- IDLE:
  - If the FIFO is non-empty, pop the head into the working registers, go to ST, k=0.
  - Otherwise, if ld_req=1 and flush=0, latch addr and len, go to LD, k=0.
  - Stores always win over loads, so every older committed store reaches RAM before any load reads.
- ST:
  - Each cycle drive ram_wr=1, ram_a = addr+k, ram_dout = wdata[8k+7:8k].
  - After byte n-1: if the FIFO is non-empty, pop the next entry back-to-back; otherwise return to IDLE with ram_wr=0.
- LD:
  - Issue phase: for n cycles drive ram_wr=0, ram_a = addr+k.
  - Capture phase: byte k is captured from ram_din one cycle later into ld_data[8k+7:8k]. Upper bytes are cleared at LD entry.
  - After the last byte is captured, go to DONE. Total is n+1 cycles in LD.
- DONE: ld_done=1 for exactly this cycle, with ld_req ignored, since the requester still holds it high here. Next state is IDLE.
- Load latency: ld_req seen in IDLE at edge E0 gives ld_done high at cycle E0+n+2. For n=4 (LW) that is 6 cycles.
- flush=1:
  - In LD: abort, return to IDLE next edge, ld_done stays 0.
  - In DONE: suppress ld_done, go to IDLE.
  - In ST: no effect; stores are committed.
  - A flush coinciding with st_req still enqueues the store.
- A store pushed while a load is in LD waits; it is served at the next IDLE.
- Address arithmetic is modulo 2^32; addr+k wraps with no fault.
- Unaligned addresses are legal; bytes are accessed individually.
- req_len outside {8, 16, 32} is treated as 32.

Decomposition:
- Shared def package gets:
  - state encodings MC_IDLE, MC_ST, MC_LD, MC_DONE;
  - length constants LEN_B=8, LEN_H=16, LEN_W=32;
  - STQ_DEPTH default.
- Natural sub-module: mem_st_fifo. It is a circular buffer of {addr, len, wdata} with push, pop, empty and full, and count-based st_full.

Test Plan:
- RAM[0x100..0x103] = 0x11,0x22,0x33,0x44; ld_req with len=32, addr=0x100 -> ld_done pulse 6 cycles later, ld_data=0x44332211, one pulse only while ld_req stays high through DONE.
- st_req len=16, addr=0x200, wdata=0xABCD1234 -> ram_wr high 2 cycles, writing 0x34@0x200 then 0x12@0x201. A following LH from 0x200 returns 0x00001234.
- Three st_req pulses on consecutive cycles (SB 0x10=0xAA, SH 0x20=0xBBCC, SW 0x30=0x01020304) while a load is pending -> all 7 bytes are written back-to-back before the load begins; st_full goes high at 3 entries.
- flush asserted during the 3rd cycle of an LW -> no ld_done, FSM back to IDLE. A new LB at 0x101 afterwards returns 0x00000022.
- rdy held low for 3 cycles mid-LW -> ram_a and captured bytes freeze; ld_done arrives 3 cycles late with correct data.
- rst asserted mid-store with 2 queued entries -> FIFO empty, ram_wr=0, ld_done=0 next cycle. Remaining stores are discarded.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store memory controller: FSM encodings,
// access-length codes, store-queue entry layout and byte helpers.
package mem_ctrl_pkg;

  localparam logic [1:0] MC_IDLE = 2'd0;
  localparam logic [1:0] MC_ST   = 2'd1;
  localparam logic [1:0] MC_LD   = 2'd2;
  localparam logic [1:0] MC_DONE = 2'd3;

  localparam logic [5:0] LEN_B = 6'd8;
  localparam logic [5:0] LEN_H = 6'd16;
  localparam logic [5:0] LEN_W = 6'd32;

  localparam int STQ_DEPTH_DEF = 4;

  // One committed store; 'last' is the index of the final byte (n-1).
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  last;
    logic [31:0] wdata;
  } st_ent_t;

  // Byte count minus one for a request length; anything unrecognised is a word.
  function automatic logic [1:0] len_last(input logic [5:0] len);
    case (len)
      LEN_B:   return 2'd0;
      LEN_H:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Little-endian byte lane select.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-bus signals between the load-store buffer,
// the memory controller and the byte-wide RAM.
interface mem_ctrl_if;
  logic        rdy;
  logic        flush;
  logic        ld_req;
  logic        st_req;
  logic [5:0]  req_len;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        st_full;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  modport slave (
    input  rdy, flush, ld_req, st_req, req_len, req_addr, req_wdata, ram_din,
    output ld_done, ld_data, st_full, ram_dout, ram_a, ram_wr
  );

  modport master (
    output rdy, flush, ld_req, st_req, req_len, req_addr, req_wdata, ram_din,
    input  ld_done, ld_data, st_full, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_st_fifo.sv
// Circular store queue holding committed stores until the RAM bus is free.
module mem_st_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int STQ_DEPTH = STQ_DEPTH_DEF,
  parameter int STQ_LOG   = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  st_ent_t push_ent_i,
  input  logic    pop_i,
  output st_ent_t head_o,
  output logic    empty_o,
  output logic    full_o,
  output logic    st_full_o
);

  localparam int CW = STQ_LOG + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(STQ_DEPTH);
  localparam logic [CW-1:0] CNT_HIGH = CW'(STQ_DEPTH - 1);

  st_ent_t            mem_q [STQ_DEPTH];
  logic [STQ_LOG-1:0] head_q, tail_q;
  logic [CW-1:0]      cnt_q, cnt_d;

  // Entry storage; contents need no reset, occupancy decides validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_ent_i;
  end

  // Occupancy follows push/pop; simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i)  head_q <= head_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign head_o    = mem_q[head_q];
  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CNT_FULL);
  assign st_full_o = (cnt_q >= CNT_HIGH);

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: drains queued stores, then serves loads, one byte per
// cycle on a single-port little-endian RAM with one-cycle read latency.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int STQ_DEPTH = STQ_DEPTH_DEF,
  parameter int STQ_LOG   = 2
) (
  input logic      clk,
  input logic      rst,
  mem_ctrl_if.slave bus
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ram_wr_q, ram_wr_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [1:0]  cap_idx;
  logic        take;

  st_ent_t stq_head;
  st_ent_t stq_in;
  logic    stq_empty, stq_full, stq_push, stq_pop;

  assign stq_in   = '{addr: bus.req_addr, last: len_last(bus.req_len), wdata: bus.req_wdata};
  assign stq_push = bus.st_req & bus.rdy;
  assign stq_pop  = take & bus.rdy;

  mem_st_fifo #(.STQ_DEPTH(STQ_DEPTH), .STQ_LOG(STQ_LOG)) u_stq (
    .clk        (clk),
    .rst        (rst),
    .push_i     (stq_push),
    .push_ent_i (stq_in),
    .pop_i      (stq_pop),
    .head_o     (stq_head),
    .empty_o    (stq_empty),
    .full_o     (stq_full),
    .st_full_o  (bus.st_full)
  );

  // Next-state: outputs are computed for the cycle after the edge, so ram_a
  // is already valid in the first ST/LD cycle. In LD, k counts 0..n; byte
  // k-1 is captured while byte k is issued, hence the extra cycle.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    addr_d     = addr_q;
    last_d     = last_q;
    wdata_d    = wdata_q;
    ram_wr_d   = ram_wr_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    ld_data_d  = ld_data_q;
    take       = 1'b0;
    cap_idx    = k_q[1:0] - 2'd1;
    case (state_q)
      MC_IDLE: begin
        if (!stq_empty) begin
          take = 1'b1;
        end else if (bus.ld_req && !bus.flush) begin
          state_d   = MC_LD;
          k_d       = '0;
          addr_d    = bus.req_addr;
          last_d    = len_last(bus.req_len);
          ram_wr_d  = 1'b0;
          ram_a_d   = bus.req_addr;
          ld_data_d = '0;
        end
      end
      MC_ST: begin
        if (k_q != {1'b0, last_q}) begin
          k_d        = k_q + 3'd1;
          ram_a_d    = addr_q + {29'd0, k_d};
          ram_dout_d = byte_of(wdata_q, k_d[1:0]);
        end else if (!stq_empty) begin
          take = 1'b1;
        end else begin
          state_d  = MC_IDLE;
          k_d      = '0;
          ram_wr_d = 1'b0;
        end
      end
      MC_LD: begin
        if (bus.flush) begin
          state_d = MC_IDLE;
          k_d     = '0;
        end else begin
          if (k_q != 3'd0) ld_data_d[{cap_idx, 3'b000} +: 8] = bus.ram_din;
          if (k_q == {1'b0, last_q} + 3'd1) begin
            state_d = MC_DONE;
            k_d     = '0;
          end else begin
            k_d = k_q + 3'd1;
            if (k_q != {1'b0, last_q}) ram_a_d = addr_q + {29'd0, k_d};
          end
        end
      end
      default: state_d = MC_IDLE;
    endcase
    // Popping a store is shared by IDLE and back-to-back ST.
    if (take) begin
      state_d    = MC_ST;
      k_d        = '0;
      addr_d     = stq_head.addr;
      last_d     = stq_head.last;
      wdata_d    = stq_head.wdata;
      ram_wr_d   = 1'b1;
      ram_a_d    = stq_head.addr;
      ram_dout_d = byte_of(stq_head.wdata, 2'd0);
    end
  end

  // FSM and registered outputs; rst wins, rdy=0 freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MC_IDLE;
      k_q        <= '0;
      ram_wr_q   <= 1'b0;
      ram_a_q    <= '0;
      ram_dout_q <= '0;
      ld_data_q  <= '0;
    end else if (bus.rdy) begin
      state_q    <= state_d;
      k_q        <= k_d;
      ram_wr_q   <= ram_wr_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ld_data_q  <= ld_data_d;
    end
  end

  // Working copy of the current access; only meaningful while ST/LD.
  always_ff @(posedge clk) begin
    if (bus.rdy) begin
      addr_q  <= addr_d;
      last_q  <= last_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.ld_done  = (state_q == MC_DONE) && !bus.flush && bus.rdy;
  assign bus.ld_data  = ld_data_q;
  assign bus.ram_wr   = ram_wr_q;
  assign bus.ram_a    = ram_a_q;
  assign bus.ram_dout = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model and write log.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if bus();

  mem_ctrl #(.STQ_DEPTH(4), .STQ_LOG(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  mem [4096];
  logic        bd_we = 1'b0;
  logic [11:0] bd_a  = '0;
  logic [7:0]  bd_d  = '0;
  logic [31:0] wa_q [$];
  logic [7:0]  wd_q [$];
  int          wc_q [$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_bad = 0;

  logic [31:0] ea [7] = '{32'h10, 32'h20, 32'h21, 32'h30, 32'h31, 32'h32, 32'h33};
  logic [7:0]  ed [7] = '{8'hAA, 8'hCC, 8'hBB, 8'h04, 8'h03, 8'h02, 8'h01};

  // RAM model: synchronous read, stalls together with the system on rdy=0
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bd_we) begin
      mem[bd_a] <= bd_d;
    end else if (bus.rdy) begin
      bus.ram_din <= mem[bus.ram_a[11:0]];
      if (bus.ram_wr) begin
        mem[bus.ram_a[11:0]] <= bus.ram_dout;
        wa_q.push_back(bus.ram_a);
        wd_q.push_back(bus.ram_dout);
        wc_q.push_back(cyc);
      end
    end
  end

  // Protocol: the requester must never push into a full queue
  always @(posedge clk) begin
    if (!rst && bus.rdy && bus.st_req)
      assert (!dut.u_stq.full_o) else $error("store pushed into a full queue");
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic st(input logic [31:0] a, input logic [5:0] l, input logic [31:0] w);
    bus.st_req = 1'b1; bus.req_addr = a; bus.req_len = l; bus.req_wdata = w;
  endtask

  // Runs one load; cycle 0 is the cycle ld_req is first raised.
  task automatic run_load(input logic [31:0] a, input logic [5:0] l,
                          input int stall_at, input int stall_n, input int flush_at,
                          output int lat, output logic [31:0] d, output int pulses,
                          output logic [31:0] a_frz, output int moved, output logic [1:0] sf);
    lat = -1; d = '0; pulses = 0; a_frz = '0; moved = 0; sf = MC_DONE;
    @(posedge clk); #1;
    bus.ld_req = 1'b1; bus.req_addr = a; bus.req_len = l;
    for (int c = 0; c < 30; c++) begin
      bus.rdy = !(c >= stall_at && c < stall_at + stall_n);
      if (c == flush_at) begin bus.flush = 1'b1; bus.ld_req = 1'b0; end
      @(negedge clk);
      if (bus.ld_done) begin
        pulses++;
        if (lat < 0) begin lat = c; d = bus.ld_data; end
      end
      if (c == stall_at) a_frz = bus.ram_a;
      if (c > stall_at && c <= stall_at + stall_n && bus.ram_a !== a_frz) moved++;
      if (c == flush_at + 1) sf = dut.state_q;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      if (lat >= 0) bus.ld_req = 1'b0;
    end
    bus.rdy = 1'b1;
  endtask

  int          lat, pul, mv, lb;
  logic [31:0] d, afz;
  logic [1:0]  sf;
  bit          got;

  initial begin
    bus.rdy = 1'b1; bus.flush = 1'b0; bus.ld_req = 1'b0; bus.st_req = 1'b0;
    bus.req_len = LEN_W; bus.req_addr = '0; bus.req_wdata = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    poke(12'hFFE, 8'hA1); poke(12'hFFF, 8'hA2); poke(12'h000, 8'hA3); poke(12'h001, 8'hA4);
    for (int i = 0; i < 4; i++) begin
      poke(12'h030 + 12'(i), 8'hEE);
      poke(12'h050 + 12'(i), 8'hEE);
    end
    @(negedge clk);
    chk("rst ld_done", {31'd0, bus.ld_done}, 32'd0);
    chk("rst ld_data", bus.ld_data, 32'd0);
    chk("rst ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    chk("rst ram_a", bus.ram_a, 32'd0);
    chk("rst ram_dout", {24'd0, bus.ram_dout}, 32'd0);
    chk("rst st_full", {31'd0, bus.st_full}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // LW 0x100, ld_req held through DONE
    run_load(32'h100, LEN_W, 99, 0, 99, lat, d, pul, afz, mv, sf);
    chk("lw latency", lat, 6);
    chk("lw data", d, 32'h44332211);
    chk("lw pulses", pul, 1);

    // SH 0x200 then LH back
    lb = wa_q.size();
    @(posedge clk); #1; st(32'h200, LEN_H, 32'hABCD1234);
    @(posedge clk); #1; bus.st_req = 1'b0;
    idle(6);
    chk("sh write count", wa_q.size() - lb, 2);
    if (wa_q.size() - lb >= 2) begin
      chk("sh a0", wa_q[lb], 32'h200);
      chk("sh d0", {24'd0, wd_q[lb]}, 32'h34);
      chk("sh a1", wa_q[lb+1], 32'h201);
      chk("sh d1", {24'd0, wd_q[lb+1]}, 32'h12);
      chk("sh back-to-back", wc_q[lb+1] - wc_q[lb], 1);
    end
    run_load(32'h200, LEN_H, 99, 0, 99, lat, d, pul, afz, mv, sf);
    chk("lh latency", lat, 4);
    chk("lh data", d, 32'h00001234);

    // Three stores queued during a load, then a load that must see them
    lb = wa_q.size();
    @(posedge clk); #1; bus.ld_req = 1'b1; bus.req_addr = 32'h100; bus.req_len = LEN_W;
    @(posedge clk); #1; st(32'h10, LEN_B, 32'h000000AA);
    @(posedge clk); #1; st(32'h20, LEN_H, 32'h0000BBCC);
    @(negedge clk); chk("stq 1 entry", {31'd0, bus.st_full}, 32'd0);
    @(posedge clk); #1; st(32'h30, LEN_W, 32'h01020304);
    @(negedge clk); chk("stq 2 entries", {31'd0, bus.st_full}, 32'd0);
    @(posedge clk); #1; bus.st_req = 1'b0;
    @(negedge clk); chk("stq 3 entries", {31'd0, bus.st_full}, 32'd1);
    got = 1'b0; d = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.ld_done) begin got = 1'b1; d = bus.ld_data; break; end
    end
    chk("load under stores done", {31'd0, got}, 32'd1);
    chk("load under stores data", d, 32'h44332211);
    @(posedge clk); #1; bus.req_addr = 32'h30; bus.req_len = LEN_W;
    got = 1'b0; d = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ld_done) begin got = 1'b1; d = bus.ld_data; break; end
    end
    @(posedge clk); #1; bus.ld_req = 1'b0;
    chk("load after stores done", {31'd0, got}, 32'd1);
    chk("load after stores data", d, 32'h01020304);
    chk("drain write count", wa_q.size() - lb, 7);
    if (wa_q.size() - lb >= 7) begin
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("drain a%0d", i), wa_q[lb+i], ea[i]);
        chk($sformatf("drain d%0d", i), {24'd0, wd_q[lb+i]}, {24'd0, ed[i]});
        chk($sformatf("drain cycle%0d", i), wc_q[lb+i] - wc_q[lb], i);
      end
    end
    idle(2);

    // Flush in the third LD cycle, then LB 0x101
    run_load(32'h100, LEN_W, 99, 0, 3, lat, d, pul, afz, mv, sf);
    chk("flush pulses", pul, 0);
    chk("flush state", {30'd0, sf}, {30'd0, MC_IDLE});
    run_load(32'h101, LEN_B, 99, 0, 99, lat, d, pul, afz, mv, sf);
    chk("lb latency", lat, 3);
    chk("lb data", d, 32'h00000022);

    // rdy low for three cycles mid-LW
    run_load(32'h100, LEN_W, 3, 3, 99, lat, d, pul, afz, mv, sf);
    chk("stall latency", lat, 9);
    chk("stall data", d, 32'h44332211);
    chk("stall ram_a value", afz, 32'h102);
    chk("stall ram_a moved", mv, 0);
    chk("stall pulses", pul, 1);

    // Odd length behaves as a word; address wraps past 0xFFFFFFFF
    run_load(32'hFFFFFFFE, 6'd24, 99, 0, 99, lat, d, pul, afz, mv, sf);
    chk("wrap latency", lat, 6);
    chk("wrap data", d, 32'hA4A3A2A1);

    // Reset mid-store with two stores still queued
    @(posedge clk); #1; st(32'h40, LEN_W, 32'h55667788);
    @(posedge clk); #1; st(32'h50, LEN_W, 32'h99AABBCC);
    @(posedge clk); #1; st(32'h60, LEN_W, 32'h11111111);
    @(posedge clk); #1; bus.st_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("pre-rst queued", {29'd0, dut.u_stq.cnt_q}, 32'd2);
    chk("pre-rst ram_wr", {31'd0, bus.ram_wr}, 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post-rst ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    chk("post-rst ld_done", {31'd0, bus.ld_done}, 32'd0);
    chk("post-rst queue", {29'd0, dut.u_stq.cnt_q}, 32'd0);
    chk("post-rst ram_a", bus.ram_a, 32'd0);
    lb = wa_q.size();
    idle(12);
    chk("post-rst writes", wa_q.size() - lb, 0);
    chk("pre-rst byte 0x40", {24'd0, mem[12'h040]}, 32'h88);
    run_load(32'h50, LEN_W, 99, 0, 99, lat, d, pul, afz, mv, sf);
    chk("discarded store", d, 32'hEEEEEEEE);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
